// File: rtl/fixedpoint_pkg.sv
// Shared Q7.8 fixed-point definitions: widths, limits, ALU opcodes, divider
// FSM states and the sign/saturation helpers used by the divider.
package fixedpoint_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_Q_WIDTH    = DEF_DATA_WIDTH + DEF_FRAC_BITS;

    localparam logic [DEF_DATA_WIDTH-1:0] Q7_8_MAX = 16'h7FFF;
    localparam logic [DEF_DATA_WIDTH-1:0] Q7_8_MIN = 16'h8000;

    typedef logic signed [15:0] q7_8_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        q7_8_t value;
        logic  ovf;
    } sat_result_t;

    // Two's-complement magnitude; 0x8000 maps to 32768 as an unsigned value.
    function automatic logic [DEF_DATA_WIDTH-1:0] abs_mag(input logic [DEF_DATA_WIDTH-1:0] x);
        return x[DEF_DATA_WIDTH-1] ? (~x + 16'd1) : x;
    endfunction

    // Negative results may reach exactly 32768 (0x8000) without overflow.
    function automatic sat_result_t apply_sign_sat(input logic neg,
                                                   input logic [DEF_Q_WIDTH-1:0] q);
        sat_result_t r;
        r.value = '0;
        r.ovf   = 1'b0;
        if (q == '0) begin
            r.value = '0;
        end else if (neg) begin
            if (q > DEF_Q_WIDTH'(Q7_8_MIN)) begin
                r.value = Q7_8_MIN;
                r.ovf   = 1'b1;
            end else begin
                r.value = ~q[DEF_DATA_WIDTH-1:0] + 16'd1;
            end
        end else if (q > DEF_Q_WIDTH'(Q7_8_MAX)) begin
            r.value = Q7_8_MAX;
            r.ovf   = 1'b1;
        end else begin
            r.value = q[DEF_DATA_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/div_fixedpoint_seq.sv
// Sequential signed Q7.8 divider: restoring division on magnitudes, one
// quotient bit per clock, with sign fix-up and saturation on the last step.
module div_fixedpoint_seq
    import fixedpoint_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z,
    output logic                  busy,
    output logic                  done
);

    localparam int ITER  = DATA_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    div_state_t            r_state;
    logic                  r_sa;
    logic                  r_sb;
    logic [DATA_WIDTH-1:0] r_absb;
    logic [ITER-1:0]       r_dvd;
    logic [DATA_WIDTH:0]   r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_n;
    logic                  r_v;
    logic                  r_z;

    logic [DATA_WIDTH:0]   w_rem_shift;
    logic                  w_ge;
    logic [DATA_WIDTH:0]   w_rem_next;
    logic [ITER-1:0]       w_q_final;
    sat_result_t           w_sat;

    // The dividend register doubles as the quotient: bits leave at the top
    // and quotient bits enter at the bottom, so after ITER steps it holds Q.
    always_comb begin
        w_rem_shift = {r_rem[DATA_WIDTH-1:0], r_dvd[ITER-1]};
        w_ge        = r_rem[DATA_WIDTH] | (w_rem_shift >= {1'b0, r_absb});
        w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_absb}) : w_rem_shift;
        w_q_final   = {r_dvd[ITER-2:0], w_ge};
        w_sat       = apply_sign_sat(r_sa ^ r_sb, w_q_final);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_absb  <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa   <= A[DATA_WIDTH-1];
                        r_sb   <= B[DATA_WIDTH-1];
                        r_absb <= abs_mag(B);
                        r_dvd  <= {abs_mag(A), {FRAC_BITS{1'b0}}};
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        if (B == '0) begin
                            r_out   <= A[DATA_WIDTH-1] ? Q7_8_MIN : Q7_8_MAX;
                            r_n     <= A[DATA_WIDTH-1];
                            r_v     <= 1'b1;
                            r_z     <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_q_final;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_out   <= w_sat.value;
                        r_n     <= w_sat.value[DATA_WIDTH-1];
                        r_v     <= w_sat.ovf;
                        r_z     <= (w_sat.value == '0);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Out  = r_out;
    assign N    = r_n;
    assign V    = r_v;
    assign Z    = r_z;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_div_fixedpoint_seq.sv
// Directed-vector bench for div_fixedpoint_seq: latency, signed results,
// saturation, divide-by-zero, start handling during CALC and mid-op reset.
module tb_div_fixedpoint_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Out;
    logic        N;
    logic        V;
    logic        Z;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    div_fixedpoint_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Out   (Out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Launch one operation, scramble operands after accept, and wait for done.
    // lat = edges after the accepting edge until done is seen (60 = timed out).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op A=%h B=%h -> Out=%h N=%b V=%b Z=%b after %0d edges", a, b, Out, N, V, Z, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({Out, N, V, Z, busy, done} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_state: got Out=%h N=%b V=%b Z=%b busy=%b done=%b, required all zero",
                     Out, N, V, Z, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        @(negedge clk);
        A = 16'h0300;
        B = 16'h0200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 16'hFFFF;
        B = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            @(posedge clk);
            #1;
        end
        $display("basic 3.0/2.0 -> Out=%h done_at=%0d busy_cycles=%0d", Out, done_at, busy_cnt);
        n_cmp++;
        if (done_at !== 24) begin
            n_err++;
            $display("FAIL basic_latency: done after %0d edges, required 24", done_at);
        end
        n_cmp++;
        if (busy_cnt !== 25) begin
            n_err++;
            $display("FAIL basic_busy: busy for %0d cycles, required 25", busy_cnt);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL basic_done_pulse: done high %0d cycles, required 1", done_cnt);
        end
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h0180, 3'b000}) begin
            n_err++;
            $display("FAIL basic_result: got Out=%h NVZ=%b%b%b, required Out=0180 NVZ=000", Out, N, V, Z);
        end
    endtask

    task automatic test_signed;
        int lat;
        run_op(16'hFD00, 16'h0200, lat);
        n_cmp++;
        if (lat !== 24) begin
            n_err++;
            $display("FAIL neg_latency: got %0d edges, required 24", lat);
        end
        n_cmp++;
        if ({Out, N, V, Z} !== {16'hFE80, 3'b100}) begin
            n_err++;
            $display("FAIL neg_div: got Out=%h NVZ=%b%b%b, required Out=fe80 NVZ=100", Out, N, V, Z);
        end
        run_op(16'h0100, 16'h0300, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h0055, 3'b000}) begin
            n_err++;
            $display("FAIL third_trunc: got Out=%h NVZ=%b%b%b, required Out=0055 NVZ=000", Out, N, V, Z);
        end
        run_op(16'hFE00, 16'hFF00, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h0200, 3'b000}) begin
            n_err++;
            $display("FAIL negneg_div: got Out=%h NVZ=%b%b%b, required Out=0200 NVZ=000", Out, N, V, Z);
        end
    endtask

    task automatic test_saturation;
        int lat;
        run_op(16'h4000, 16'h0080, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h7FFF, 3'b010}) begin
            n_err++;
            $display("FAIL pos_sat: got Out=%h NVZ=%b%b%b, required Out=7fff NVZ=010", Out, N, V, Z);
        end
        run_op(16'h8000, 16'h0100, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h8000, 3'b100}) begin
            n_err++;
            $display("FAIL neg_min_exact: got Out=%h NVZ=%b%b%b, required Out=8000 NVZ=100", Out, N, V, Z);
        end
        run_op(16'h8000, 16'hFF00, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h7FFF, 3'b010}) begin
            n_err++;
            $display("FAIL min_by_neg1: got Out=%h NVZ=%b%b%b, required Out=7fff NVZ=010", Out, N, V, Z);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run_op(16'h0100, 16'h0000, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_err++;
            $display("FAIL dz_latency: done after %0d edges, required 0 (visible right after accept)", lat);
        end
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h7FFF, 3'b010}) begin
            n_err++;
            $display("FAIL dz_pos: got Out=%h NVZ=%b%b%b, required Out=7fff NVZ=010", Out, N, V, Z);
        end
        run_op(16'hFF00, 16'h0000, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h8000, 3'b110}) begin
            n_err++;
            $display("FAIL dz_neg: got Out=%h NVZ=%b%b%b, required Out=8000 NVZ=110", Out, N, V, Z);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({Out, N, V, Z, busy, done} !== {16'h8000, 3'b110, 2'b00}) begin
            n_err++;
            $display("FAIL dz_hold: got Out=%h NVZ=%b%b%b busy=%b done=%b, required 8000 110 idle",
                     Out, N, V, Z, busy, done);
        end
    endtask

    task automatic test_zero_dividend;
        int lat;
        run_op(16'h0000, 16'h0300, lat);
        n_cmp++;
        if (lat !== 24) begin
            n_err++;
            $display("FAIL zero_latency: got %0d edges, required 24", lat);
        end
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h0000, 3'b001}) begin
            n_err++;
            $display("FAIL zero_dividend: got Out=%h NVZ=%b%b%b, required Out=0000 NVZ=001", Out, N, V, Z);
        end
    endtask

    task automatic test_back_to_back;
        int lat = 0;
        @(negedge clk);
        A = 16'h0300;
        B = 16'h0200;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        A = 16'h0100;
        B = 16'h0300;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("b2b first -> Out=%h after %0d edges", Out, lat);
        n_cmp++;
        if (lat !== 24) begin
            n_err++;
            $display("FAIL b2b_first_latency: got %0d edges, required 24", lat);
        end
        n_cmp++;
        if (Out !== 16'h0180) begin
            n_err++;
            $display("FAIL b2b_first_result: got Out=%h, required 0180 (operands changed in CALC)", Out);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_after_done: busy=%b, required 0 (start ignored in DONE)", busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_accept: busy=%b, required 1 on first IDLE edge", busy);
        end
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("b2b second -> Out=%h after %0d edges", Out, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'h0055, 3'b000} || lat !== 24) begin
            n_err++;
            $display("FAIL b2b_second_result: got Out=%h NVZ=%b%b%b lat=%0d, required 0055 000 lat=24",
                     Out, N, V, Z, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int done_cnt = 0;
        int busy_cnt = 0;
        int lat;
        @(negedge clk);
        A = 16'h0300;
        B = 16'h0200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("reset at iteration 10 -> Out=%h busy=%b done=%b", Out, busy, done);
        n_cmp++;
        if ({Out, N, V, Z, busy, done} !== 21'h0) begin
            n_err++;
            $display("FAIL midreset_state: got Out=%h NVZ=%b%b%b busy=%b done=%b, required all zero",
                     Out, N, V, Z, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        n_cmp++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            n_err++;
            $display("FAIL midreset_abandon: done seen %0d, busy seen %0d, required 0 and 0", done_cnt, busy_cnt);
        end
        run_op(16'hFD00, 16'h0200, lat);
        n_cmp++;
        if ({Out, N, V, Z} !== {16'hFE80, 3'b100}) begin
            n_err++;
            $display("FAIL midreset_recover: got Out=%h NVZ=%b%b%b, required Out=fe80 NVZ=100", Out, N, V, Z);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_saturation();
        test_div_zero();
        test_zero_dividend();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
